// File: rtl/fx2_wr_arbiter.sv
// FX2 slave-FIFO write arbiter: merges command replies and per-channel
// sample words into one byte stream and commits short packets on reply
// end or after an idle timeout.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | pick next source: reply first, else round-robin channel
// WORD    | stream latched word, LSB byte first, stalls on full
// REPLY   | write one reply byte, then re-arbitrate or commit packet
// PKTEND  | pulse pktend to commit the partial packet
module fx2_wr_arbiter #(
    parameter int N_CH       = 2,
    parameter int WORD_BYTES = 6,
    parameter int PKT_BYTES  = 512,
    parameter int IDLE_FLUSH = 1024
) (
    input  logic                         fx2_clk,
    input  logic                         rst_n,
    input  logic                         fx2_full_n,
    output logic                         fx2_slwr,
    output logic                         fx2_pktend,
    output logic [7:0]                   fx2_fd_out,
    output logic                         fx2_fd_oe,
    input  logic [N_CH*WORD_BYTES*8-1:0] ch_data,
    input  logic [N_CH-1:0]              ch_rdy,
    output logic [N_CH-1:0]              ch_ack,
    input  logic [7:0]                   reply,
    input  logic                         reply_rdy,
    output logic                         reply_ack,
    input  logic                         reply_end
);

    localparam int PW    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int BW    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int CW    = $clog2(PKT_BYTES);
    localparam int WBITS = WORD_BYTES * 8;

    localparam logic [15:0]   FLUSH_TC  = 16'(IDLE_FLUSH - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(WORD_BYTES - 1);
    localparam logic [PW:0]   N_CH_W    = (PW + 1)'(N_CH);
    localparam logic [PW-1:0] LAST_CH   = PW'(N_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WORD   = 2'd1,
        S_REPLY  = 2'd2,
        S_PKTEND = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [PW-1:0]   r_rr_ptr;
    logic [WBITS-1:0] r_word;
    logic [BW-1:0]   r_byte_idx;
    logic [CW-1:0]   r_pkt_cnt;
    logic [15:0]     r_idle_cnt;

    logic [2*N_CH-1:0] w_rdy2;
    logic [2*N_CH-1:0] w_rdy_rot;
    logic [PW-1:0]     w_off;
    logic [PW:0]       w_sum;
    logic [PW-1:0]     w_grant_ch;
    logic [PW-1:0]     w_next_ptr;
    logic              w_grant_any;
    logic [CW-1:0]     w_pkt_inc;
    logic              w_idle_count;
    logic              w_take_word;
    logic              w_write;
    logic              w_pkt_clr;

    // Round-robin pick: rotate ready vector so rr_ptr sits at bit 0,
    // take the lowest set bit, then map the offset back to a channel.
    always_comb begin
        w_rdy2      = {ch_rdy, ch_rdy};
        w_rdy_rot   = w_rdy2 >> r_rr_ptr;
        w_grant_any = |ch_rdy;
        w_off       = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (w_rdy_rot[i]) w_off = PW'(i);
        end
        w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
        if (w_sum >= N_CH_W) w_sum = w_sum - N_CH_W;
        w_grant_ch = w_sum[PW-1:0];
        w_next_ptr = (w_grant_ch == LAST_CH) ? '0 : w_grant_ch + 1'b1;
    end

    assign w_pkt_inc    = r_pkt_cnt + 1'b1;
    assign w_idle_count = (r_state == S_IDLE) && !reply_rdy && !w_grant_any &&
                          (r_pkt_cnt != '0);

    // Next-state and strobe decode; every output is a function of the
    // current state so reset forces them inactive without waiting a clock.
    always_comb begin
        w_next      = r_state;
        fx2_slwr    = 1'b1;
        fx2_pktend  = 1'b1;
        fx2_fd_out  = 8'h00;
        fx2_fd_oe   = 1'b0;
        ch_ack      = '0;
        reply_ack   = 1'b0;
        w_take_word = 1'b0;
        w_write     = 1'b0;
        w_pkt_clr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (reply_rdy) begin
                    w_next = S_REPLY;
                end else if (w_grant_any) begin
                    ch_ack      = N_CH'(1) << w_grant_ch;
                    w_take_word = 1'b1;
                    w_next      = S_WORD;
                end else if (w_idle_count && (r_idle_cnt == FLUSH_TC)) begin
                    w_next = S_PKTEND;
                end
            end
            S_WORD: begin
                fx2_fd_oe  = 1'b1;
                fx2_fd_out = r_word[int'(r_byte_idx)*8 +: 8];
                if (fx2_full_n) begin
                    fx2_slwr = 1'b0;
                    w_write  = 1'b1;
                    if (r_byte_idx == LAST_BYTE) w_next = S_IDLE;
                end
            end
            S_REPLY: begin
                fx2_fd_oe  = 1'b1;
                fx2_fd_out = reply;
                if (!reply_rdy) begin
                    w_next = S_IDLE;
                end else if (fx2_full_n) begin
                    fx2_slwr  = 1'b0;
                    reply_ack = 1'b1;
                    w_write   = 1'b1;
                    // A reply ending exactly on a packet boundary was already
                    // auto-committed by the FX2, so there is nothing to flush.
                    if (reply_end && (w_pkt_inc != '0)) w_next = S_PKTEND;
                    else                                w_next = S_IDLE;
                end
            end
            S_PKTEND: begin
                fx2_fd_oe = 1'b1;
                if (fx2_full_n) begin
                    fx2_pktend = 1'b0;
                    w_pkt_clr  = 1'b1;
                    w_next     = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (!rst_n) begin
            ch_ack    = '0;
            reply_ack = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge fx2_clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Word latch, byte index, round-robin pointer, packet and idle counters.
    always_ff @(posedge fx2_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_word     <= '0;
            r_byte_idx <= '0;
            r_pkt_cnt  <= '0;
            r_idle_cnt <= '0;
        end else begin
            if (w_take_word) begin
                r_word     <= ch_data[int'(w_grant_ch)*WBITS +: WBITS];
                r_byte_idx <= '0;
                r_rr_ptr   <= w_next_ptr;
            end else if ((r_state == S_WORD) && fx2_full_n) begin
                r_byte_idx <= r_byte_idx + 1'b1;
            end
            if (w_pkt_clr)    r_pkt_cnt <= '0;
            else if (w_write) r_pkt_cnt <= w_pkt_inc;
            if (w_idle_count && (r_idle_cnt != FLUSH_TC)) r_idle_cnt <= r_idle_cnt + 1'b1;
            else                                          r_idle_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_fx2_wr_arbiter.sv
// Bench for fx2_wr_arbiter: queued word/reply sources, a per-cycle monitor
// of the written byte stream, and a queue-level round-robin model.
module tb_fx2_wr_arbiter;

    logic        fx2_clk, rst_n, fx2_full_n;
    logic        fx2_slwr, fx2_pktend, fx2_fd_oe;
    logic [7:0]  fx2_fd_out;
    logic [95:0] ch_data;
    logic [1:0]  ch_rdy, ch_ack;
    logic [7:0]  reply;
    logic        reply_rdy, reply_ack, reply_end;

    fx2_wr_arbiter #(.N_CH(2), .WORD_BYTES(6), .PKT_BYTES(64), .IDLE_FLUSH(16)) dut (
        .fx2_clk(fx2_clk), .rst_n(rst_n), .fx2_full_n(fx2_full_n),
        .fx2_slwr(fx2_slwr), .fx2_pktend(fx2_pktend), .fx2_fd_out(fx2_fd_out),
        .fx2_fd_oe(fx2_fd_oe), .ch_data(ch_data), .ch_rdy(ch_rdy), .ch_ack(ch_ack),
        .reply(reply), .reply_rdy(reply_rdy), .reply_ack(reply_ack), .reply_end(reply_end)
    );

    initial fx2_clk = 1'b0;
    always #5 fx2_clk = ~fx2_clk;

    int n_checks = 0, n_fail = 0;
    int cyc, first_wr_cyc, last_wr_cyc, pe_cyc, n_rack;
    int stall_at, stall_left, inj_at;
    bit inj_pending, rand_bp;
    logic [47:0] src0[$], src1[$];
    logic [8:0]  rep_q[$], inj_q[$];
    logic [7:0]  q_wr[$], q_held[$], exp_b[$];
    int          q_pe[$], q_grant[$], exp_g[$];

    task automatic drive_inputs();
        ch_rdy[0]     = (src0.size() != 0);
        ch_rdy[1]     = (src1.size() != 0);
        ch_data[47:0] = ch_rdy[0] ? src0[0] : 48'h0;
        ch_data[95:48] = ch_rdy[1] ? src1[0] : 48'h0;
        reply_rdy     = (rep_q.size() != 0);
        {reply_end, reply} = reply_rdy ? rep_q[0] : 9'h0;
    endtask

    // One clock: observe at the falling edge, update sources after the rising edge.
    task automatic step();
        bit pop0, pop1, popr;
        @(negedge fx2_clk);
        cyc++;
        if (rst_n) begin
            n_checks++;
            if ((!fx2_slwr && !fx2_pktend) !== 1'b0) begin
                n_fail++; $display("FAIL strobe_overlap: slwr=%b pktend=%b want not both 0", fx2_slwr, fx2_pktend);
            end
            n_checks++;
            if ((!fx2_slwr && !fx2_full_n) !== 1'b0) begin
                n_fail++; $display("FAIL write_when_full: slwr=%b full_n=%b want slwr 1", fx2_slwr, fx2_full_n);
            end
            n_checks++;
            if (((!fx2_slwr || !fx2_pktend) && !fx2_fd_oe) !== 1'b0) begin
                n_fail++; $display("FAIL oe_on_strobe: oe=%b want 1", fx2_fd_oe);
            end
            n_checks++;
            if ((ch_ack & ~ch_rdy) !== 2'b00) begin
                n_fail++; $display("FAIL ack_not_ready: ack=%b rdy=%b", ch_ack, ch_rdy);
            end
        end
        pop0 = ch_ack[0];
        pop1 = ch_ack[1];
        popr = reply_ack;
        if (ch_ack[0]) q_grant.push_back(0);
        if (ch_ack[1]) q_grant.push_back(1);
        if (!fx2_slwr) begin
            if (q_wr.size() == 0) first_wr_cyc = cyc;
            q_wr.push_back(fx2_fd_out);
            last_wr_cyc = cyc;
        end
        if (!fx2_pktend) begin
            q_pe.push_back(q_wr.size());
            pe_cyc = cyc;
        end
        if (fx2_fd_oe && fx2_slwr && fx2_pktend) q_held.push_back(fx2_fd_out);
        @(posedge fx2_clk);
        #1;
        if (pop0 && src0.size() != 0) void'(src0.pop_front());
        if (pop1 && src1.size() != 0) void'(src1.pop_front());
        if (popr && rep_q.size() != 0) begin
            void'(rep_q.pop_front());
            n_rack++;
        end
        if (inj_pending && q_wr.size() == inj_at) begin
            foreach (inj_q[i]) rep_q.push_back(inj_q[i]);
            inj_pending = 0;
        end
        if (stall_left > 0 && q_wr.size() >= stall_at) begin
            fx2_full_n = 1'b0;
            stall_left--;
        end else if (rand_bp) begin
            fx2_full_n = ($urandom_range(0, 3) != 0);
        end else begin
            fx2_full_n = 1'b1;
        end
        drive_inputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        src0.delete(); src1.delete(); rep_q.delete(); inj_q.delete();
        fx2_full_n = 1'b1; rand_bp = 0; stall_left = 0; inj_pending = 0;
        drive_inputs();
        step(); step();
        q_wr.delete(); q_held.delete(); q_pe.delete(); q_grant.delete();
        exp_b.delete(); exp_g.delete();
        n_rack = 0; cyc = 0; first_wr_cyc = 0; last_wr_cyc = 0; pe_cyc = 0;
        rst_n = 1'b1;
    endtask

    // Run until all sources are consumed and the DUT is idle, then a few more cycles.
    task automatic drain(input int budget, input int extra, input string name);
        int n = 0;
        while (n < budget && !(src0.size() == 0 && src1.size() == 0 && rep_q.size() == 0 &&
                               !inj_pending && fx2_fd_oe == 1'b0)) begin
            step();
            n++;
        end
        n_checks++;
        if (n >= budget) begin
            n_fail++; $display("FAIL %s_timeout: still busy after %0d cycles", name, n);
        end
        repeat (extra) step();
    endtask

    function automatic int stream_diff();
        int d = 0;
        if (q_wr.size() != exp_b.size()) return 1000 + q_wr.size();
        foreach (q_wr[i]) if (q_wr[i] !== exp_b[i]) d++;
        return d;
    endfunction

    function automatic int grant_diff();
        int d = 0;
        if (q_grant.size() != exp_g.size()) return 1000 + q_grant.size();
        foreach (q_grant[i]) if (q_grant[i] != exp_g[i]) d++;
        return d;
    endfunction

    task automatic push_word_bytes(input logic [47:0] w);
        for (int i = 0; i < 6; i++) exp_b.push_back(w[i*8 +: 8]);
    endtask

    // Round-robin over channels with pending words, pointer starting at 0.
    task automatic model_rr();
        int pend[2];
        int idx[2];
        int ptr = 0;
        pend[0] = src0.size(); pend[1] = src1.size();
        idx[0] = 0; idx[1] = 0;
        while (pend[0] + pend[1] > 0) begin
            for (int k = 0; k < 2; k++) begin
                int c = (ptr + k) % 2;
                if (pend[c] > 0) begin
                    exp_g.push_back(c);
                    push_word_bytes(c == 0 ? src0[idx[0]] : src1[idx[1]]);
                    idx[c]++; pend[c]--;
                    ptr = (c + 1) % 2;
                    break;
                end
            end
        end
    endtask

    function automatic logic [47:0] rand_word();
        logic [63:0] t = {$urandom(), $urandom()};
        return t[47:0];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        fx2_full_n = 1'b1;
        src0.push_back(48'h060504030201);
        rep_q.push_back(9'h1AA);
        drive_inputs();
        step(); step();
        n_checks++;
        if (fx2_slwr !== 1'b1) begin n_fail++; $display("FAIL reset_slwr: got %b want 1", fx2_slwr); end
        n_checks++;
        if (fx2_pktend !== 1'b1) begin n_fail++; $display("FAIL reset_pktend: got %b want 1", fx2_pktend); end
        n_checks++;
        if (fx2_fd_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b want 0", fx2_fd_oe); end
        n_checks++;
        if (fx2_fd_out !== 8'h00) begin n_fail++; $display("FAIL reset_fd: got %h want 00", fx2_fd_out); end
        n_checks++;
        if (ch_ack !== 2'b00) begin n_fail++; $display("FAIL reset_ch_ack: got %b want 00", ch_ack); end
        n_checks++;
        if (reply_ack !== 1'b0) begin n_fail++; $display("FAIL reset_reply_ack: got %b want 0", reply_ack); end
    endtask

    task automatic test_single_word_flush();
        do_reset();
        src0.push_back(48'h060504030201);
        for (int i = 1; i <= 6; i++) exp_b.push_back(8'(i));
        drive_inputs();
        drain(40, 40, "single");
        n_checks++;
        if (q_grant.size() != 1 || q_grant[0] != 0) begin
            n_fail++; $display("FAIL single_grant: got %0d grants want one on ch0", q_grant.size());
        end
        n_checks++;
        if (stream_diff() != 0) begin
            n_fail++; $display("FAIL single_bytes: got %0d bytes diff=%0d want 6 bytes 01..06", q_wr.size(), stream_diff());
        end
        n_checks++;
        if (last_wr_cyc - first_wr_cyc != 5) begin
            n_fail++; $display("FAIL single_contiguous: byte span %0d want 5", last_wr_cyc - first_wr_cyc);
        end
        n_checks++;
        if (q_pe.size() != 1) begin
            n_fail++; $display("FAIL flush_count: got %0d pktend pulses want 1", q_pe.size());
        end
        n_checks++;
        if (pe_cyc - last_wr_cyc != 17) begin
            n_fail++; $display("FAIL flush_delay: pktend %0d cycles after last byte want 17", pe_cyc - last_wr_cyc);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        do_reset();
        src1.push_back(48'hA6A5A4A3A2A1);
        exp_g.push_back(1);
        push_word_bytes(48'hA6A5A4A3A2A1);
        stall_at = 2; stall_left = 5;
        drive_inputs();
        drain(60, 5, "bp");
        n_checks++;
        if (grant_diff() != 0) begin n_fail++; $display("FAIL bp_grant: got %0d grants want one on ch1", q_grant.size()); end
        n_checks++;
        if (stream_diff() != 0) begin
            n_fail++; $display("FAIL bp_bytes: got %0d bytes diff=%0d want A1..A6 once", q_wr.size(), stream_diff());
        end
        n_checks++;
        if (q_held.size() != 5) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d want 5", q_held.size()); end
        foreach (q_held[i]) if (q_held[i] !== 8'hA3) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL bp_held_byte: %0d stall cycles not showing A3", bad); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            src0.push_back(rand_word());
            src1.push_back(rand_word());
        end
        model_rr();
        drive_inputs();
        drain(200, 5, "rr");
        n_checks++;
        if (grant_diff() != 0) begin n_fail++; $display("FAIL rr_order: %0d grant diffs want 0,1,0,1..", grant_diff()); end
        n_checks++;
        if (stream_diff() != 0) begin n_fail++; $display("FAIL rr_bytes: got %0d bytes diff=%0d want 48", q_wr.size(), stream_diff()); end
    endtask

    task automatic test_reply_priority();
        do_reset();
        src0.push_back(48'h1F1E1D1C1B1A);
        rep_q.push_back(9'h0C1); rep_q.push_back(9'h0C2); rep_q.push_back(9'h1C3);
        exp_b.push_back(8'hC1); exp_b.push_back(8'hC2); exp_b.push_back(8'hC3);
        push_word_bytes(48'h1F1E1D1C1B1A);
        exp_g.push_back(0);
        drive_inputs();
        drain(80, 5, "prio");
        n_checks++;
        if (stream_diff() != 0) begin n_fail++; $display("FAIL prio_bytes: got %0d bytes diff=%0d want reply then word", q_wr.size(), stream_diff()); end
        n_checks++;
        if (n_rack != 3) begin n_fail++; $display("FAIL prio_reply_ack: got %0d want 3", n_rack); end
        n_checks++;
        if (q_pe.size() != 1 || q_pe[0] != 3) begin n_fail++; $display("FAIL prio_pktend: got %0d pulses want 1 after byte 3", q_pe.size()); end
        n_checks++;
        if (grant_diff() != 0) begin n_fail++; $display("FAIL prio_grant: got %0d grants want one on ch0", q_grant.size()); end
    endtask

    task automatic test_reply_midword();
        do_reset();
        src0.push_back(48'h2625242322_21);
        push_word_bytes(48'h262524232221);
        exp_b.push_back(8'hD1); exp_b.push_back(8'hD2);
        inj_q.push_back(9'h0D1); inj_q.push_back(9'h1D2);
        inj_at = 2; inj_pending = 1;
        drive_inputs();
        drain(80, 5, "midword");
        n_checks++;
        if (stream_diff() != 0) begin n_fail++; $display("FAIL midword_bytes: got %0d bytes diff=%0d want word then reply", q_wr.size(), stream_diff()); end
        n_checks++;
        if (q_pe.size() != 1 || q_pe[0] != 8) begin n_fail++; $display("FAIL midword_pktend: got %0d pulses want 1 after byte 8", q_pe.size()); end
    endtask

    task automatic test_wrap_flush();
        do_reset();
        for (int w = 0; w < 11; w++) begin
            logic [47:0] v;
            for (int b = 0; b < 6; b++) v[b*8 +: 8] = 8'(w * 6 + b);
            src0.push_back(v);
            push_word_bytes(v);
        end
        drive_inputs();
        drain(200, 30, "wrap");
        n_checks++;
        if (stream_diff() != 0) begin n_fail++; $display("FAIL wrap_bytes: got %0d bytes diff=%0d want 66", q_wr.size(), stream_diff()); end
        n_checks++;
        if (q_pe.size() != 1 || q_pe[0] != 66) begin n_fail++; $display("FAIL wrap_flush: got %0d pulses want 1 after byte 66", q_pe.size()); end
    endtask

    task automatic test_exact_packet();
        do_reset();
        for (int w = 0; w < 10; w++) begin
            src0.push_back(rand_word());
            push_word_bytes(src0[w]);
        end
        for (int i = 0; i < 4; i++) begin
            inj_q.push_back({(i == 3) ? 1'b1 : 1'b0, 8'(8'hE0 + i)});
            exp_b.push_back(8'(8'hE0 + i));
        end
        inj_at = 60; inj_pending = 1;
        drive_inputs();
        drain(200, 40, "exact");
        n_checks++;
        if (stream_diff() != 0) begin n_fail++; $display("FAIL exact_bytes: got %0d bytes diff=%0d want 64", q_wr.size(), stream_diff()); end
        n_checks++;
        if (q_pe.size() != 0) begin n_fail++; $display("FAIL exact_zero_len: got %0d pktend pulses want 0", q_pe.size()); end
        n_checks++;
        if (n_rack != 4) begin n_fail++; $display("FAIL exact_reply_ack: got %0d want 4", n_rack); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int n0, n1, total, exp_pe;
            do_reset();
            n0 = $urandom_range(0, 4);
            n1 = $urandom_range(0, 4);
            for (int i = 0; i < n0; i++) src0.push_back(rand_word());
            for (int i = 0; i < n1; i++) src1.push_back(rand_word());
            model_rr();
            total = exp_b.size();
            exp_pe = (total % 64 != 0) ? 1 : 0;
            rand_bp = 1;
            drive_inputs();
            drain(400, 60, "rand");
            n_checks++;
            if (grant_diff() != 0) begin n_fail++; $display("FAIL rand_grants it%0d: %0d diffs (n0=%0d n1=%0d)", it, grant_diff(), n0, n1); end
            n_checks++;
            if (stream_diff() != 0) begin n_fail++; $display("FAIL rand_bytes it%0d: got %0d bytes diff=%0d want %0d", it, q_wr.size(), stream_diff(), total); end
            n_checks++;
            if (q_pe.size() != exp_pe || (exp_pe == 1 && q_pe[0] != total)) begin
                n_fail++; $display("FAIL rand_flush it%0d: got %0d pulses want %0d", it, q_pe.size(), exp_pe);
            end
        end
        rand_bp = 0;
    endtask

    task automatic test_reset_midword();
        int n = 0;
        do_reset();
        src0.push_back(48'h363534333231);
        drive_inputs();
        while (q_wr.size() < 3 && n < 20) begin step(); n++; end
        n_checks++;
        if (q_wr.size() != 3) begin n_fail++; $display("FAIL rstmid_setup: got %0d bytes want 3", q_wr.size()); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({fx2_slwr, fx2_pktend, fx2_fd_oe, fx2_fd_out, ch_ack, reply_ack} !== {1'b1, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0}) begin
            n_fail++; $display("FAIL rstmid_outputs: slwr=%b pktend=%b oe=%b fd=%h ack=%b rack=%b want 1 1 0 00 00 0",
                               fx2_slwr, fx2_pktend, fx2_fd_oe, fx2_fd_out, ch_ack, reply_ack);
        end
        step(); step();
        rst_n = 1'b1;
        repeat (40) step();
        n_checks++;
        if (q_wr.size() != 3) begin n_fail++; $display("FAIL rstmid_discard: got %0d bytes want 3", q_wr.size()); end
        n_checks++;
        if (q_pe.size() != 0) begin n_fail++; $display("FAIL rstmid_no_flush: got %0d pktend pulses want 0", q_pe.size()); end
    endtask

    initial begin
        rst_n = 1'b0; fx2_full_n = 1'b1;
        ch_data = '0; ch_rdy = '0; reply = '0; reply_rdy = 1'b0; reply_end = 1'b0;
        stall_at = 0; stall_left = 0; inj_at = 0; inj_pending = 0; rand_bp = 0;
        n_rack = 0; cyc = 0;
        test_reset();
        test_single_word_flush();
        test_backpressure();
        test_round_robin();
        test_reply_priority();
        test_reply_midword();
        test_wrap_flush();
        test_exact_packet();
        test_random();
        test_reset_midword();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fx2_wr_arbiter.md
FX2_WR_ARBITER -- requirements
Module: fx2_wr_arbiter

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of sample channels, legal range 1..8.
REQ-002 SHALL have parameter WORD_BYTES, default 6, bytes per sample word, legal range 1..8.
REQ-003 SHALL have parameter PKT_BYTES, default 512, FX2 endpoint packet size in bytes, power of two, 64..1024.
REQ-004 SHALL have parameter IDLE_FLUSH, default 1024, idle cycles before a partial packet is committed, legal range 1..65535.
REQ-005 SHALL have port fx2_clk, input, 1 bit, sole clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port fx2_full_n, input, 1 bit, endpoint FIFO not-full flag, pre-synchronised.
REQ-008 SHALL have port fx2_slwr, output, 1 bit, active-low write strobe.
REQ-009 SHALL have port fx2_pktend, output, 1 bit, active-low packet commit.
REQ-010 SHALL have port fx2_fd_out, output, 8 bits, write data.
REQ-011 SHALL have port fx2_fd_oe, output, 1 bit, data bus output enable.
REQ-012 SHALL have port ch_data, input, N_CH*WORD_BYTES*8 bits, channel c word in slice c.
REQ-013 SHALL have port ch_rdy, input, N_CH bits, per-channel word valid.
REQ-014 SHALL have port ch_ack, output, N_CH bits, one-cycle word-consumed pulse.
REQ-015 SHALL have port reply, input, 8 bits, command reply byte.
REQ-016 SHALL have port reply_rdy, input, 1 bit, reply byte valid.
REQ-017 SHALL have port reply_ack, output, 1 bit, reply byte consumed.
REQ-018 SHALL have port reply_end, input, 1 bit, qualifies the last byte of a reply.

Function
REQ-019 SHALL implement states IDLE, WORD, REPLY and PKTEND.
REQ-020 In IDLE, reply_rdy SHALL win over any ch_rdy; the next state is REPLY.
REQ-021 Otherwise, in IDLE, a round-robin grant SHALL go to the first ready channel at or after rr_ptr, going up and wrapping at N_CH.
REQ-022 On a grant, ch_ack[c] SHALL pulse for exactly one cycle and the word SHALL be latched in that cycle.
REQ-023 On a grant, rr_ptr SHALL become (c+1) mod N_CH; the next state is WORD.
REQ-024 In WORD, latched bytes SHALL be emitted LSB byte first, one byte per cycle while fx2_full_n=1.
REQ-025 In WORD, fx2_slwr SHALL be low and fx2_fd_out valid in the same cycle as each byte.
REQ-026 While fx2_full_n=0, fx2_slwr SHALL be high and the current byte held; no byte is lost or duplicated.
REQ-027 A word SHALL never be interleaved with reply bytes; a reply arriving mid-word waits until WORD finishes.
REQ-028 After the last byte of a word, the state SHALL return to IDLE.
REQ-029 In REPLY, each byte written SHALL assert reply_ack in the same cycle as fx2_slwr low.
REQ-030 After a reply byte written with reply_end=1, the state SHALL go to PKTEND.
REQ-031 After a reply byte with reply_end=0, the state SHALL return to IDLE.
REQ-032 A packet byte counter SHALL increment per written byte and wrap to 0 at PKT_BYTES (FX2 auto-commit).
REQ-033 PKTEND SHALL drive fx2_pktend low for one cycle, only when fx2_full_n=1, then reset the packet counter and go to IDLE.
REQ-034 PKTEND SHALL be skipped (straight to IDLE) if the packet counter is 0, so zero-length packets are never sent.
REQ-035 An idle counter SHALL count cycles in IDLE with no request and a non-zero packet counter.
REQ-036 The idle counter SHALL clear on any grant; when it reaches IDLE_FLUSH, the state SHALL go to PKTEND.
REQ-037 fx2_fd_oe SHALL be 1 in WORD, REPLY and PKTEND, and 0 in IDLE.
REQ-038 fx2_slwr and fx2_pktend SHALL never be low in the same cycle.

Reset
REQ-039 While rst_n=0, outputs SHALL be: fx2_slwr=1, fx2_pktend=1, fx2_fd_oe=0, fx2_fd_out=0, ch_ack=0, reply_ack=0.
REQ-040 While rst_n=0, internal state SHALL be: state=IDLE, rr_ptr=0, packet and idle counters=0.
REQ-041 Reset asserted mid-word SHALL discard the partial word with no further strobes; deassertion takes effect on the next fx2_clk edge.

Verification
REQ-042 Single word: N_CH=2, WORD_BYTES=6, ch_rdy=01, data 0x060504030201 -> one ch_ack[0] pulse, then six slwr-low cycles carrying 01,02,03,04,05,06.
REQ-043 Round-robin: both channels ready continuously -> grants alternate 0,1,0,1 with no channel starved.
REQ-044 Back-pressure: full_n=0 for 5 cycles after byte 2 -> slwr high for those 5 cycles, byte 3 held, all 6 bytes delivered once each.
REQ-045 Reply priority and end: reply_rdy and ch_rdy raised together, 3-byte reply with reply_end on the last byte -> reply bytes first, 3 reply_ack pulses, one pktend pulse, then the word.
REQ-046 Idle flush: IDLE_FLUSH=16, one 6-byte word, then silence -> pktend pulses once, 16 cycles after returning to IDLE; nothing further follows.
REQ-047 Wrap and reset: PKT_BYTES=64 with 11 words (66 bytes) -> the counter wraps, and a flush commits 2 bytes; rst_n pulsed mid-word -> all outputs return to reset values immediately.
